// File: rtl/sdram_rom_loader.sv
// Packs the 8-bit ROM download into 16-bit words and writes them through the two SDRAM toggle ports.
// Odd strobe -> request toggle on the next edge. ioctl_wait stalls the downloader until the ack matches the request.
module sdram_rom_loader #(
    parameter logic [24:0] P2_BASE = 25'h0400000,
    parameter logic [24:0] ROM_END = 25'h0800000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic        port1_we,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic        port2_we,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        rom_loaded,
    output logic [21:0] words_written
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FLUSH, DONE} state_t;

    state_t      state;
    state_t      state_nxt;

    logic        dl_q;
    logic        end_pend;
    logic        flushing;
    logic        cur_p2;
    logic        lo_valid;
    logic [7:0]  lo_buf;
    logic [23:0] pend_word;

    logic        dl_fall;
    logic        dl_rise;
    logic        flush_now;
    logic        accept;
    logic        odd_stb;
    logic        even_stb;
    logic        even_flush;
    logic        evt;
    logic        issue_go;
    logic        to_p2;
    logic        acked;
    logic [24:0] w_addr;
    logic [15:0] w_dat;
    logic [1:0]  w_ds;
    logic [22:0] w_a;

    assign dl_fall    = dl_q && !ioctl_download;
    assign dl_rise    = !dl_q && ioctl_download;
    assign flush_now  = (state == IDLE) && (dl_fall || end_pend);
    assign accept     = ioctl_wr && ioctl_download && (state == IDLE) && !end_pend;
    assign odd_stb    = accept && ioctl_addr[0];
    assign even_stb   = accept && !ioctl_addr[0];
    assign even_flush = even_stb && lo_valid && (pend_word != ioctl_addr[24:1]);

    // Word candidate: either the odd byte completing a word, or the buffered half word being flushed.
    always_comb begin
        w_addr = {ioctl_addr[24:1], 1'b0};
        w_dat  = {ioctl_dout, lo_buf};
        w_ds   = {1'b1, lo_valid};
        evt    = odd_stb;
        if (flush_now || even_flush) begin
            w_addr = {pend_word, 1'b0};
            w_dat  = {8'h00, lo_buf};
            w_ds   = 2'b01;
            evt    = lo_valid;
        end
    end

    assign to_p2    = (w_addr >= P2_BASE);
    assign w_a      = to_p2 ? (w_addr[23:1] - P2_BASE[23:1]) : w_addr[23:1];
    assign issue_go = evt && (w_addr < ROM_END);
    assign acked    = cur_p2 ? (port2_ack == port2_req) : (port1_ack == port1_req);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (flush_now) begin
                    state_nxt = issue_go ? FLUSH : DONE;
                end else if (issue_go) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            FLUSH:   state_nxt = WAIT;
            WAIT: begin
                if (acked) begin
                    state_nxt = flushing ? DONE : IDLE;
                end
            end
            DONE: begin
                if (dl_rise) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ioctl_wait = (state == ISSUE) || (state == WAIT) || (state == FLUSH) || (accept && issue_go);
        rom_loaded = (state == DONE);
    end

    // Port registers load on the edge that enters ISSUE/FLUSH and hold until the next word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dl_q          <= 1'b0;
            end_pend      <= 1'b0;
            flushing      <= 1'b0;
            cur_p2        <= 1'b0;
            lo_valid      <= 1'b0;
            lo_buf        <= 8'h00;
            pend_word     <= 24'h0;
            port1_req     <= 1'b0;
            port1_we      <= 1'b0;
            port1_a       <= 23'h0;
            port1_ds      <= 2'b00;
            port1_d       <= 16'h0;
            port2_req     <= 1'b0;
            port2_we      <= 1'b0;
            port2_a       <= 23'h0;
            port2_ds      <= 2'b00;
            port2_d       <= 16'h0;
            words_written <= 22'h0;
        end else begin
            dl_q     <= ioctl_download;
            end_pend <= (state != IDLE) && (state != DONE) && (end_pend || dl_fall);

            if ((state == IDLE) && issue_go) begin
                cur_p2   <= to_p2;
                flushing <= flush_now;
                if (to_p2) begin
                    port2_req <= ~port2_req;
                    port2_we  <= 1'b1;
                    port2_a   <= w_a;
                    port2_ds  <= w_ds;
                    port2_d   <= w_dat;
                end else begin
                    port1_req <= ~port1_req;
                    port1_we  <= 1'b1;
                    port1_a   <= w_a;
                    port1_ds  <= w_ds;
                    port1_d   <= w_dat;
                end
            end
            if (state == DONE) begin
                flushing <= 1'b0;
            end

            // A flushing even byte re-fills the buffer in the same cycle, so lo_valid stays set.
            if (flush_now || odd_stb) begin
                lo_valid <= 1'b0;
            end else if (even_stb) begin
                lo_valid  <= 1'b1;
                lo_buf    <= ioctl_dout;
                pend_word <= ioctl_addr[24:1];
            end

            if (dl_rise) begin
                words_written <= 22'h0;
            end else if ((state == WAIT) && acked && (words_written != {22{1'b1}})) begin
                words_written <= words_written + 22'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_rom_loader.sv
// Directed bench: byte writes drive the loader, a scoreboard of expected port words is checked on each req toggle.
module tb_sdram_rom_loader;

    localparam logic [24:0] P2_BASE = 25'h0400000;
    localparam logic [24:0] ROM_END = 25'h0800000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        port1_req;
    logic        port1_ack = 1'b0;
    logic        port1_we;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port2_req;
    logic        port2_ack = 1'b0;
    logic        port2_we;
    logic [22:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;
    logic        rom_loaded;
    logic [21:0] words_written;

    always #5 clk = ~clk;

    sdram_rom_loader dut (
        .clk(clk), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .port1_req(port1_req), .port1_ack(port1_ack), .port1_we(port1_we),
        .port1_a(port1_a), .port1_ds(port1_ds), .port1_d(port1_d),
        .port2_req(port2_req), .port2_ack(port2_ack), .port2_we(port2_we),
        .port2_a(port2_a), .port2_ds(port2_ds), .port2_d(port2_d),
        .rom_loaded(rom_loaded), .words_written(words_written)
    );

    typedef struct {
        int          port;
        logic [22:0] a;
        logic [15:0] d;
        logic [1:0]  ds;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   ack_delay = 3;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input int port, input logic [22:0] a, input logic [15:0] d, input logic [1:0] ds);
        exp_t e;
        e.port = port; e.a = a; e.d = d; e.ds = ds;
        exp_q.push_back(e);
    endtask

    task automatic compare_word(input int port, input logic other, input logic [22:0] a,
                                input logic [15:0] d, input logic [1:0] ds, input logic we);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("req_expected", 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check("port_word", {other, 2'(port), a, d, ds, we}, {1'b0, 2'(e.port), e.a, e.d, e.ds, 1'b1});
        end
    endtask

    // Controller model: detects req toggles, checks them, and acks after ack_delay cycles.
    logic p1_prev = 1'b0, p2_prev = 1'b0;
    bit   p1_pend = 1'b0, p2_pend = 1'b0;
    int   p1_cnt = 0, p2_cnt = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            p1_prev   = port1_req;
            p2_prev   = port2_req;
            p1_pend   = 1'b0;
            p2_pend   = 1'b0;
            port1_ack = 1'b0;
            port2_ack = 1'b0;
        end else begin
            if (p1_pend) begin
                if (p1_cnt == 0) begin port1_ack = port1_req; p1_pend = 1'b0; end
                else p1_cnt--;
            end
            if (p2_pend) begin
                if (p2_cnt == 0) begin port2_ack = port2_req; p2_pend = 1'b0; end
                else p2_cnt--;
            end
            if (port1_req !== p1_prev) begin
                compare_word(1, port2_req !== p2_prev, port1_a, port1_d, port1_ds, port1_we);
                p1_prev = port1_req; p1_pend = 1'b1; p1_cnt = ack_delay;
            end
            if (port2_req !== p2_prev) begin
                compare_word(2, port1_req !== p1_prev, port2_a, port2_d, port2_ds, port2_we);
                p2_prev = port2_req; p2_pend = 1'b1; p2_cnt = ack_delay;
            end
        end
    end

    task automatic write_byte(input logic [24:0] addr, input logic [7:0] dat, input int exp_wait);
        @(posedge clk); #1;
        ioctl_wr = 1'b1; ioctl_addr = addr; ioctl_dout = dat;
        #1;
        if (exp_wait >= 0) check("strobe_wait", ioctl_wait, 64'(exp_wait[0]));
        @(posedge clk); #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (ioctl_wait === 1'b0) break;
        end
        check({tag, "_idle"}, ioctl_wait, 0);
    endtask

    initial begin
        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {port1_req, port1_we, port1_a, port1_ds, port1_d}, 0);
        check("rst_outputs2", {port2_req, port2_we, port2_a, port2_ds, port2_d}, 0);
        check("rst_status", {ioctl_wait, rom_loaded, words_written}, 0);
        reset_n = 1'b1; ioctl_download = 1'b1;
        @(posedge clk); #1;

        // Basic port-1 word
        write_byte(25'd0, 8'h34, 0);
        expect_word(1, 23'd0, 16'h1234, 2'b11);
        write_byte(25'd1, 8'h12, 1);
        wait_idle("t1");
        check("t1_words", words_written, 1);

        // Port-2 word
        write_byte(P2_BASE + 25'd6, 8'hCD, 0);
        expect_word(2, 23'd3, 16'hABCD, 2'b11);
        write_byte(P2_BASE + 25'd7, 8'hAB, 1);
        wait_idle("t2");
        check("t2_reqs", {port1_req, port2_req}, 2'b11);
        check("t2_words", words_written, 2);

        // Long ack latency: stall and stable outputs
        ack_delay = 50;
        write_byte(25'd8, 8'h11, 0);
        expect_word(1, 23'd4, 16'h2211, 2'b11);
        write_byte(25'd9, 8'h22, 1);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            check("hold_wait", ioctl_wait, 1);
            check("hold_out", {port1_a, port1_d, port1_ds, port1_we}, {23'd4, 16'h2211, 2'b11, 1'b1});
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (port1_ack === port1_req) break;
        end
        check("hold_release", ioctl_wait, 0);
        ack_delay = 3;

        // Even byte at a new word flushes the pending half word
        write_byte(25'd6, 8'h66, 0);
        expect_word(1, 23'd3, 16'h0066, 2'b01);
        write_byte(25'd10, 8'h77, -1);
        wait_idle("ef1");
        expect_word(1, 23'd5, 16'h8877, 2'b11);
        write_byte(25'd11, 8'h88, 1);
        wait_idle("ef2");
        check("ef_words", words_written, 5);

        // Out-of-range bytes are dropped
        write_byte(ROM_END, 8'h99, 0);
        write_byte(ROM_END + 25'd1, 8'h9A, 0);
        repeat (5) @(posedge clk);
        #1;
        check("drop_reqs", {port1_req, port2_req}, 2'b01);
        check("drop_words", words_written, 5);

        // End of download flushes the half word, then completes
        write_byte(25'd4, 8'h55, 0);
        expect_word(1, 23'd2, 16'h0055, 2'b01);
        @(posedge clk); #1;
        ioctl_download = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (rom_loaded === 1'b1) break;
        end
        check("flush_loaded", rom_loaded, 1);
        check("flush_words", words_written, 6);
        check("flush_status", {ioctl_wait, port1_req}, 2'b01);

        // New download clears status
        @(posedge clk); #1;
        ioctl_download = 1'b1;
        @(posedge clk); #1;
        check("restart_status", {rom_loaded, words_written}, 0);

        write_byte(25'h30, 8'h01, 0);
        expect_word(1, 23'h18, 16'h0201, 2'b11);
        write_byte(25'h31, 8'h02, 1);
        wait_idle("r1");
        check("r1_words", words_written, 1);

        // Reset while waiting for an ack
        ack_delay = 20;
        write_byte(25'h20, 8'hAA, 0);
        expect_word(1, 23'h10, 16'hBBAA, 2'b11);
        write_byte(25'h21, 8'hBB, 1);
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst", {ioctl_wait, port1_req, port2_req}, 3'b111);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_p1", {port1_req, port1_we, port1_a, port1_ds, port1_d}, 0);
        check("mid_rst_p2", {port2_req, port2_we, port2_a, port2_ds, port2_d}, 0);
        check("mid_rst_status", {ioctl_wait, rom_loaded, words_written}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        ack_delay = 3;
        expect_word(1, 23'h20, 16'h2211, 2'b11);
        write_byte(25'h40, 8'h11, 0);
        write_byte(25'h41, 8'h22, 1);
        wait_idle("post_rst");
        check("post_rst_req", {port1_req, port2_req}, 2'b10);
        check("post_rst_words", words_written, 1);

        repeat (10) @(posedge clk);
        #1;
        check("sb_empty", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
